fft3_input_framer: RTL and testbench
====================================

// Module: fft3_input_framer
// PURPOSE
//  Upstream framer for the mixed-size radix-3 DFT (3/9/27/81/243 pt) in the PUSCH transform-precoding chain.
//  Accepts a valid/ready sample stream and buffers one block of N=3^k samples in a ping-pong RAM.
//  Replays each block to the FFT as one gap-free di_en burst, with the FFT stage select set up ahead of the burst.
//  Holds the stage select stable while a different-size block drains through the FFT.
// PARAMETERS
//  WIDTH        18   sample component width (re and im, two's complement)
//  SETUP_CYC    2    cycles fft_stages is held before the first fft_en of a burst (min 1)
//  DRAIN_CYC    512  idle cycles inserted before a burst whose k differs from the previous burst's k
// PORTS
//  clk         in   1      clock
//  rst         in   1      reset, asynchronous, active-high
//  cfg_stages  in   3      k for the next block (1..5); sampled on the first accepted sample of a block
//  s_valid     in   1      input sample valid
//  s_ready     out  1      framer can accept a sample
//  s_re        in   WIDTH  input sample, real part
//  s_im        in   WIDTH  input sample, imaginary part
//  fft_stages  out  3      stage select to FFT (Stages)
//  fft_en      out  1      FFT input enable (di_en)
//  fft_re      out  WIDTH  FFT input, real part (di_re)
//  fft_im      out  WIDTH  FFT input, imaginary part (di_im)
//  cfg_err     out  1      1-cycle pulse: block start with illegal cfg_stages
//  busy        out  1      any bank is non-EMPTY, or the reader is not IDLE
// BEHAVIOUR
//  - Reset values: fft_en=0, fft_re=0, fft_im=0, fft_stages=0, cfg_err=0, busy=0.
//    s_ready is combinational and equals 1 once rst is released.
//  - Accept = s_valid & s_ready. Length table N(k) = {3,9,27,81,243} for k=1..5.
//  - Block start (write count 0): latch k = cfg_stages.
//    - If k is 0, 6 or 7: sample is consumed and dropped, cfg_err pulses next cycle, and the next accepted sample is again a block start.
//  - Per-bank state: EMPTY -> FILLING -> FULL -> READING -> EMPTY. Each bank stores its own k.
//  - s_ready = 1 iff the write bank is EMPTY or FILLING.
//  - On the N-th accept the bank goes FULL and the write pointer toggles to the other bank.
//  - Reader FSM: IDLE -> [GAP] -> SETUP -> BURST -> IDLE.
//    - IDLE -> GAP when the read bank is FULL, a prior burst exists, and its k != the previous burst's k. GAP lasts DRAIN_CYC cycles.
//    - IDLE -> SETUP otherwise.
//    - SETUP: fft_stages = k for SETUP_CYC cycles; the bank goes READING on SETUP entry.
//    - BURST: fft_en = 1 for exactly N consecutive cycles, samples in arrival order, no bubbles.
//    - On the last burst cycle the bank goes EMPTY, the read pointer toggles, and the reader returns to IDLE.
//  - fft_stages keeps the last burst's k after the burst ends; it never returns to 0 except on reset. This keeps the downstream output mux valid.
//  - fft_re and fft_im are 0 whenever fft_en = 0. RAM read is registered; the address runs 1 cycle ahead of fft_en.
//  - Latency (reader IDLE, no GAP): first fft_en is asserted SETUP_CYC+1 cycles after the edge accepting the N-th sample.
//  - Simultaneous fill of one bank and burst of the other is fully supported.
//    - A bank freed on the edge where the writer is stalled on it raises s_ready the next cycle.
//  - Reset mid-block or mid-burst: both banks discarded, FSMs to IDLE/EMPTY; fft_en drops asynchronously.
//  - cfg_stages changes mid-block are ignored until the next block start.
// STRUCTURE
//  - Package fft3_pkg holds:
//    - STG_MIN=1, STG_MAX=5, MAX_N=243;
//    - function blk_len(k);
//    - bank-state enum {EMPTY, FILLING, FULL, READING};
//    - reader-state enum {IDLE, GAP, SETUP, BURST}.
//  - Sub-module fft3_pingpong_ram: 2 x MAX_N x 2*WIDTH simple dual-port RAM, 1 write port, 1 registered read port, bank-select address bit.
//  - Top-level RTL holds the counters, bank states, reader FSM and output registers.
// TESTING
//  1. k=1, 3 back-to-back samples (1,2,3) with im=0.
//     -> fft_stages=1; fft_en high exactly 3 consecutive cycles; fft_re 1,2,3; first fft_en 3 cycles after last accept.
//  2. k=5, 486 samples streamed with s_valid=1 throughout.
//     -> two 243-cycle bursts; s_ready never drops; no GAP since k is unchanged; order preserved.
//  3. Block k=2 then a block with cfg_stages=3.
//     -> 9-cycle burst, then DRAIN_CYC idle cycles, then fft_stages=3 held SETUP_CYC cycles, then a 27-cycle burst.
//  4. cfg_stages=0 at block start, then cfg_stages=1 with 3 samples.
//     -> cfg_err single pulse; first sample dropped; next 3 samples form a k=1 burst.
//  5. Reader busy with a 243-pt burst while 2 more blocks arrive.
//     -> s_ready low after the second bank fills; s_ready rises the cycle after the first burst ends; no sample lost.
//  6. rst asserted at burst cycle 40 of 81.
//     -> fft_en=0 immediately; busy=0; s_ready=1 after release; a following k=1 block bursts correctly.

Source files
------------

// File: rtl/fft3_pkg.sv
// fft3_pkg: shared constants, block-length lookup and state types for the radix-3 DFT input framer
package fft3_pkg;
    localparam int STG_MIN = 1;
    localparam int STG_MAX = 5;
    localparam int MAX_N   = 243;
    localparam int IDX_W   = 8;
    typedef enum logic [1:0] {EMPTY, FILLING, FULL, READING} bank_state_t;
    typedef enum logic [1:0] {IDLE, GAP, SETUP, BURST} rd_state_t;
    function automatic logic [IDX_W-1:0] blk_len(input logic [2:0] k);
        return k == 3'd1 ? 8'd3 : k == 3'd2 ? 8'd9 : k == 3'd3 ? 8'd27 :
               k == 3'd4 ? 8'd81 : k == 3'd5 ? 8'd243 : 8'd0;
    endfunction
    function automatic logic stg_ok(input logic [2:0] k);
        return k >= 3'(STG_MIN) && k <= 3'(STG_MAX);
    endfunction
endpackage

// File: rtl/fft3_input_framer_if.sv
// fft3_input_framer_if: sample stream in, FFT feed out, plus config/status of the framer
//  cfg_stages/s_valid/s_re/s_im  -> framer       s_ready                    <- framer
//  fft_stages/fft_en/fft_re/fft_im/cfg_err/busy <- framer
interface fft3_input_framer_if #(parameter int WIDTH = 18);
    logic [2:0]       cfg_stages;
    logic             s_valid;
    logic             s_ready;
    logic [WIDTH-1:0] s_re;
    logic [WIDTH-1:0] s_im;
    logic [2:0]       fft_stages;
    logic             fft_en;
    logic [WIDTH-1:0] fft_re;
    logic [WIDTH-1:0] fft_im;
    logic             cfg_err;
    logic             busy;
    modport master (
        output cfg_stages, s_valid, s_re, s_im,
        input  s_ready, fft_stages, fft_en, fft_re, fft_im, cfg_err, busy
    );
    modport slave (
        input  cfg_stages, s_valid, s_re, s_im,
        output s_ready, fft_stages, fft_en, fft_re, fft_im, cfg_err, busy
    );
endinterface

// File: rtl/fft3_pingpong_ram.sv
// fft3_pingpong_ram: two banks of MAX_N words, one write port, one registered read port
//  clk                   clock
//  we/wbank/widx/wdata   write enable, bank, index within bank, data
//  rbank/ridx/rdata      read bank, index, registered data (one cycle after address)
module fft3_pingpong_ram
    import fft3_pkg::*;
#(
    parameter int DW = 36
) (
    input  logic             clk,
    input  logic             we,
    input  logic             wbank,
    input  logic [IDX_W-1:0] widx,
    input  logic [DW-1:0]    wdata,
    input  logic             rbank,
    input  logic [IDX_W-1:0] ridx,
    output logic [DW-1:0]    rdata
);
    logic [DW-1:0] mem [2][MAX_N];
    always_ff @(posedge clk) begin
        if (we) mem[wbank][widx] <= wdata;
        rdata <= mem[rbank][ridx];
    end
endmodule

// File: rtl/fft3_input_framer.sv
// fft3_input_framer: buffers 3^k-sample blocks in a ping-pong RAM and replays each as a gap-free FFT burst
//  clk   clock
//  rst   asynchronous active-high reset
//  bus   slave side of fft3_input_framer_if: sample stream in (valid/ready), FFT feed out
//        (fft_stages/fft_en/fft_re/fft_im), cfg_err pulse on illegal block start, busy status
module fft3_input_framer
    import fft3_pkg::*;
#(
    parameter int WIDTH     = 18,
    parameter int SETUP_CYC = 2,
    parameter int DRAIN_CYC = 512
) (
    input  logic               clk,
    input  logic               rst,
    fft3_input_framer_if.slave bus
);
    localparam int CW = 16;
    bank_state_t      bank_st [2];
    logic [2:0]       bank_k  [2];
    logic             wptr, rptr;
    logic [IDX_W-1:0] wcnt, rcnt, rlen;
    logic [2:0]       prev_k, wk, rk, stg_q;
    logic             have_prev, en_q, err_q;
    rd_state_t        rd_st;
    logic [CW-1:0]    cnt;
    logic [2*WIDTH-1:0] rdata;
    logic             accept, first, wr_en, last_wr, need_gap, go_setup;

    assign bus.s_ready = !rst && (bank_st[wptr] == EMPTY || bank_st[wptr] == FILLING);
    assign accept      = bus.s_valid && bus.s_ready;
    assign first       = wcnt == '0;
    // k comes from the config port only on the first sample; later samples use the bank's latched k
    assign wk          = first ? bus.cfg_stages : bank_k[wptr];
    assign wr_en       = accept && stg_ok(wk);
    assign last_wr     = wcnt == blk_len(wk) - 1'b1;
    assign rk          = bank_k[rptr];
    assign rlen        = blk_len(rk);
    assign need_gap    = have_prev && rk != prev_k;
    assign go_setup    = (rd_st == IDLE && bank_st[rptr] == FULL && !need_gap) || (rd_st == GAP && cnt == '0);

    assign bus.fft_en     = en_q;
    assign bus.fft_stages = stg_q;
    assign bus.cfg_err    = err_q;
    assign bus.fft_re     = en_q ? rdata[2*WIDTH-1:WIDTH] : '0;
    assign bus.fft_im     = en_q ? rdata[WIDTH-1:0] : '0;
    assign bus.busy       = bank_st[0] != EMPTY || bank_st[1] != EMPTY || rd_st != IDLE;

    // rcnt is the index of the next sample to read, so the RAM address leads fft_en by one cycle
    fft3_pingpong_ram #(.DW(2*WIDTH)) u_ram (
        .clk   (clk),
        .we    (wr_en),
        .wbank (wptr),
        .widx  (wcnt),
        .wdata ({bus.s_re, bus.s_im}),
        .rbank (rptr),
        .ridx  (rcnt),
        .rdata (rdata)
    );

    // Writer and reader touch bank states in disjoint phases (EMPTY/FILLING vs FULL/READING),
    // so their updates never collide even when both pointers name the same bank.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bank_st[0] <= EMPTY;
            bank_st[1] <= EMPTY;
            bank_k[0]  <= '0;
            bank_k[1]  <= '0;
            wptr       <= 1'b0;
            rptr       <= 1'b0;
            wcnt       <= '0;
            rcnt       <= '0;
            prev_k     <= '0;
            have_prev  <= 1'b0;
            rd_st      <= IDLE;
            cnt        <= '0;
            en_q       <= 1'b0;
            stg_q      <= '0;
            err_q      <= 1'b0;
        end else begin
            err_q <= accept && !stg_ok(wk);
            if (wr_en) begin
                if (first) bank_k[wptr] <= wk;
                bank_st[wptr] <= last_wr ? FULL : FILLING;
                wcnt          <= last_wr ? '0 : wcnt + 1'b1;
                if (last_wr) wptr <= ~wptr;
            end
            if (go_setup) begin
                rd_st         <= SETUP;
                cnt           <= CW'(SETUP_CYC - 1);
                bank_st[rptr] <= READING;
                stg_q         <= rk;
                prev_k        <= rk;
                have_prev     <= 1'b1;
            end else begin
                case (rd_st)
                    IDLE: if (bank_st[rptr] == FULL) begin
                        rd_st <= GAP;
                        cnt   <= CW'(DRAIN_CYC - 1);
                    end
                    GAP: cnt <= cnt - 1'b1;
                    SETUP: if (cnt == '0) begin
                        rd_st <= BURST;
                        en_q  <= 1'b1;
                        rcnt  <= rcnt + 1'b1;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                    BURST: if (rcnt == rlen) begin
                        en_q          <= 1'b0;
                        rcnt          <= '0;
                        bank_st[rptr] <= EMPTY;
                        rptr          <= ~rptr;
                        rd_st         <= IDLE;
                    end else begin
                        rcnt <= rcnt + 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_fft3_input_framer.sv
// tb_fft3_input_framer: scoreboard bench for the radix-3 DFT input framer
module tb_fft3_input_framer;
    localparam int WIDTH     = 18;
    localparam int SETUP_CYC = 2;
    localparam int DRAIN_CYC = 512;

    typedef struct { int k; int re; int im; } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fft3_input_framer_if #(.WIDTH(WIDTH)) bus ();
    fft3_input_framer #(.WIDTH(WIDTH), .SETUP_CYC(SETUP_CYC), .DRAIN_CYC(DRAIN_CYC)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    exp_t q[$];
    int checks = 0, failures = 0;
    int cyc = 0, acc_cyc = 0, rdy_cyc = -1, end5_cyc = -2;
    int exp_err = 0, err_seen = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    function automatic int blen(input int k);
        int n = 1;
        repeat (k) n *= 3;
        return n;
    endfunction

    // Monitor: pops the scoreboard on every fft_en cycle and checks burst framing
    int run = 0, low = 0, prev_k = 0, cur_k = 0;
    logic en_d = 1'b0;
    int hist [SETUP_CYC];
    exp_t e;
    always @(negedge clk) begin
        if (rst) begin
            run = 0; low = 0; prev_k = 0; en_d = 1'b0;
        end else begin
            if (bus.cfg_err) err_seen++;
            if (bus.fft_en) begin
                if (!en_d) begin
                    cur_k = q.size() > 0 ? q[0].k : -1;
                    for (int i = 0; i < SETUP_CYC; i++) chk("setup_stages", hist[i], cur_k);
                    if (prev_k != 0)
                        chk("inter_burst_gap", int'(low >= (prev_k != cur_k ? DRAIN_CYC : 0) + SETUP_CYC + 1), 1);
                end
                if (q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_sample actual=fft_en_high required=no_output re=%0d", bus.fft_re);
                end else begin
                    e = q.pop_front();
                    chk("fft_re", int'(bus.fft_re), e.re);
                    chk("fft_im", int'(bus.fft_im), e.im);
                    chk("fft_stages", int'(bus.fft_stages), e.k);
                end
                run++;
            end else begin
                if (en_d) begin
                    chk("burst_len", run, blen(cur_k));
                    chk("stages_hold", int'(bus.fft_stages), cur_k);
                    if (cur_k == 5) end5_cyc = cyc;
                    prev_k = cur_k;
                    run = 0;
                    low = 0;
                end
                chk("idle_data_zero", int'(bus.fft_re) | int'(bus.fft_im), 0);
                low++;
            end
            en_d = bus.fft_en;
        end
        for (int i = SETUP_CYC - 1; i > 0; i--) hist[i] = hist[i-1];
        hist[0] = int'(bus.fft_stages);
    end

    // Drive one sample starting at a negedge; returns at the negedge after it is accepted
    task automatic send(input int cfg, input int re, input int im, output int st);
        bus.cfg_stages = 3'(cfg);
        bus.s_valid    = 1'b1;
        bus.s_re       = WIDTH'(re);
        bus.s_im       = WIDTH'(im);
        st = 0;
        while (!bus.s_ready && st < 3000) begin
            @(negedge clk);
            st++;
        end
        if (st > 0) rdy_cyc = cyc;
        if (!bus.s_ready) chk("s_ready_timeout", 0, 1);
        @(posedge clk);
        @(negedge clk);
        bus.s_valid = 1'b0;
        acc_cyc = cyc;
    endtask

    task automatic send_block(input int k, input int gap_max, output int stall_tot);
        int st, re, im;
        stall_tot = 0;
        for (int i = 0; i < blen(k); i++) begin
            re = int'($urandom_range(0, (1 << WIDTH) - 1));
            im = int'($urandom_range(0, (1 << WIDTH) - 1));
            repeat ($urandom_range(0, gap_max)) @(negedge clk);
            q.push_back('{k, re, im});
            send(i == 0 ? k : int'($urandom_range(0, 7)), re, im, st);
            stall_tot += st;
        end
    endtask

    task automatic send_bad(input int cfg);
        int st;
        send(cfg, int'($urandom_range(0, 1000)), 0, st);
        exp_err++;
        chk("cfg_err_pulse", int'(bus.cfg_err), 1);
        @(negedge clk);
        chk("cfg_err_single", int'(bus.cfg_err), 0);
    endtask

    task automatic wait_en(input int lat);
        int t = 0;
        while (!bus.fft_en && t < 3000) begin
            @(negedge clk);
            t++;
        end
        chk("first_en_latency", cyc - acc_cyc, lat);
    endtask

    task automatic wait_idle();
        int t = 0;
        while ((q.size() != 0 || bus.busy) && t < 30000) begin
            @(negedge clk);
            t++;
        end
        chk("drain_done", int'(t < 30000), 1);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #700000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int st, tot;
        int bad [3] = '{0, 6, 7};
        bus.cfg_stages = '0;
        bus.s_valid    = 1'b0;
        bus.s_re       = '0;
        bus.s_im       = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_fft_en", int'(bus.fft_en), 0);
        chk("rst_fft_re", int'(bus.fft_re), 0);
        chk("rst_fft_im", int'(bus.fft_im), 0);
        chk("rst_fft_stages", int'(bus.fft_stages), 0);
        chk("rst_cfg_err", int'(bus.cfg_err), 0);
        chk("rst_busy", int'(bus.busy), 0);
        chk("rst_s_ready", int'(bus.s_ready), 1);
        @(negedge clk);

        // k=1 block 1,2,3: reader idle, first burst after reset
        for (int i = 1; i <= 3; i++) begin
            q.push_back('{1, i, 0});
            send(1, i, 0, st);
        end
        wait_en(SETUP_CYC + 1);
        wait_idle();

        // two k=5 blocks streamed continuously
        send_block(5, 0, tot);
        send_block(5, 0, st);
        chk("k5_stream_no_stall", tot + st, 0);
        wait_idle();

        // k=2 then k=3: the k change forces a drain gap
        send_block(2, 0, st);
        wait_idle();
        send_block(3, 0, st);
        wait_en(1 + DRAIN_CYC + SETUP_CYC);
        wait_idle();

        // illegal start is dropped, then a k=1 block
        send_bad(0);
        send_block(1, 0, st);
        wait_idle();

        // 243-pt block followed by two small blocks: the third must wait for bank release
        send_block(5, 0, st);
        send_block(1, 0, st);
        send_block(1, 0, tot);
        chk("s_ready_low_when_full", int'(tot > 0), 1);
        wait_idle();
        chk("s_ready_rise_after_burst", rdy_cyc, end5_cyc);

        // reset in the middle of an 81-pt burst
        send_block(4, 0, st);
        st = 0;
        while (!bus.fft_en && st < 3000) begin
            @(negedge clk);
            st++;
        end
        chk("burst81_started", int'(bus.fft_en), 1);
        repeat (39) @(negedge clk);
        #2;
        rst = 1'b1;
        q.delete();
        #1;
        chk("midburst_rst_fft_en", int'(bus.fft_en), 0);
        chk("midburst_rst_busy", int'(bus.busy), 0);
        chk("midburst_rst_fft_re", int'(bus.fft_re), 0);
        @(negedge clk);
        @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        chk("post_rst_s_ready", int'(bus.s_ready), 1);
        @(negedge clk);
        send_block(1, 0, st);
        wait_en(SETUP_CYC + 1);
        wait_idle();

        // randomized blocks with input gaps and occasional illegal starts
        for (int b = 0; b < 10; b++) begin
            if ($urandom_range(0, 3) == 0) send_bad(bad[$urandom_range(0, 2)]);
            send_block(int'($urandom_range(1, 4)), 2, st);
        end
        wait_idle();

        chk("scoreboard_empty", q.size(), 0);
        chk("final_busy", int'(bus.busy), 0);
        chk("cfg_err_count", err_seen, exp_err);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
